// File: rtl/inst_fetch_prefetch.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue between a 1-cycle-latency
// instruction memory and decode; decode stalls do not stop fetching until the queue fills.
module inst_fetch_prefetch #(
    parameter int                      ADDR_WIDTH = 10,
    parameter int                      INST_WIDTH = 32,
    parameter int                      DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]   NOP_INST   = 32'h60000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          jump,
    input  logic [ADDR_WIDTH-1:0]         new_pc,
    input  logic                          hold,
    output logic                          imem_en,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [INST_WIDTH-1:0]         imem_rdata,
    output logic [ADDR_WIDTH-1:0]         dec_pc,
    output logic [INST_WIDTH-1:0]         dec_inst,
    output logic                          dec_valid,
    output logic [$clog2(DEPTH+1)-1:0]    q_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [ADDR_WIDTH-1:0] dec_pc_q, dec_pc_d;
    logic [INST_WIDTH-1:0] dec_inst_q, dec_inst_d;
    logic                  dec_valid_q, dec_valid_d;

    logic [ADDR_WIDTH-1:0] qpc_q   [DEPTH];
    logic [INST_WIDTH-1:0] qinst_q [DEPTH];

    logic             resp_vld;
    logic             load;
    logic             q_empty;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             fetch_ok;
    logic [LVL_W:0]   committed;

    // A response arriving in the same cycle as a jump belongs to the old stream and is dropped.
    assign resp_vld  = inflight_q && !jump;
    assign committed = {1'b0, level_q} + (LVL_W+1)'(inflight_q);
    assign fetch_ok  = committed < (LVL_W+1)'(DEPTH);

    assign imem_en   = reset && (jump || fetch_ok);
    assign imem_addr = jump ? new_pc : fetch_pc_q;

    assign load    = !hold || !dec_valid_q;
    assign q_empty = (level_q == '0);
    assign pop     = load && !q_empty;
    assign bypass  = load && q_empty && resp_vld;
    assign push    = resp_vld && !bypass;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = imem_en;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        dec_pc_d    = dec_pc_q;
        dec_inst_d  = dec_inst_q;
        dec_valid_d = dec_valid_q;

        if (imem_en) begin
            fetch_pc_d = imem_addr + ADDR_WIDTH'(1);
        end

        if (load) begin
            if (pop) begin
                dec_pc_d    = qpc_q[rd_ptr_q];
                dec_inst_d  = qinst_q[rd_ptr_q];
                dec_valid_d = 1'b1;
            end else if (bypass) begin
                dec_pc_d    = infl_pc_q;
                dec_inst_d  = imem_rdata;
                dec_valid_d = 1'b1;
            end else begin
                dec_inst_d  = NOP_INST;
                dec_valid_d = 1'b0;
            end
        end

        // Redirect: discard everything queued; the target read is issued this very cycle.
        if (jump) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            level_d     = '0;
            dec_pc_d    = new_pc;
            dec_inst_d  = NOP_INST;
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            dec_pc_q    <= RESET_PC;
            dec_inst_q  <= NOP_INST;
            dec_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            dec_pc_q    <= dec_pc_d;
            dec_inst_q  <= dec_inst_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    // Payload storage carries no reset; the control pointers decide what is live.
    always_ff @(posedge clk) begin
        infl_pc_q <= imem_addr;
        if (push) begin
            qpc_q[wr_ptr_q]   <= infl_pc_q;
            qinst_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign dec_pc    = dec_pc_q;
    assign dec_inst  = dec_inst_q;
    assign dec_valid = dec_valid_q;
    assign q_level   = level_q;

endmodule

// File: tb/tb_inst_fetch_prefetch.sv
// Directed bench for inst_fetch_prefetch: memory returns mem[i]=i one cycle after a read.
module tb_inst_fetch_prefetch;

    localparam int AW = 10;
    localparam int IW = 32;
    localparam int D  = 4;
    localparam logic [31:0] NOP = 32'h60000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          jump;
    logic [AW-1:0] new_pc;
    logic          hold;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [AW-1:0] dec_pc;
    logic [IW-1:0] dec_inst;
    logic          dec_valid;
    logic [2:0]    q_level;

    int passed = 0;
    int total  = 0;

    inst_fetch_prefetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .jump       (jump),
        .new_pc     (new_pc),
        .hold       (hold),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dec_pc     (dec_pc),
        .dec_inst   (dec_inst),
        .dec_valid  (dec_valid),
        .q_level    (q_level)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'(imem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_dec(input string tag, input int pc, input logic vld);
        chk({tag, ".valid"}, 32'(dec_valid), 32'(vld));
        chk({tag, ".pc"},    32'(dec_pc),    32'(pc));
        chk({tag, ".inst"},  dec_inst,       vld ? 32'(pc) : NOP);
    endtask

    initial begin
        reset  = 1'b0;
        jump   = 1'b0;
        new_pc = '0;
        hold   = 1'b0;

        // Reset state
        step();
        step();
        chk_dec("rst", 0, 1'b0);
        chk("rst.q_level", 32'(q_level), 0);
        chk("rst.imem_en", 32'(imem_en), 0);

        // T1: release reset, sequential fetch from 0
        reset = 1'b1;
        #1;
        chk("t1.imem_en", 32'(imem_en), 1);
        chk("t1.imem_addr", 32'(imem_addr), 0);
        step();
        chk("t1.first_bubble", 32'(dec_valid), 0);
        step();
        chk_dec("t1.pc0", 0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_dec("t1.seq", k, 1'b1);
        end

        // T2: hold at pc 20 for 10 cycles
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_dec("t2.held", 20, 1'b1);
        end
        chk("t2.q_full", 32'(q_level), 4);
        chk("t2.imem_off", 32'(imem_en), 0);
        hold = 1'b0;
        step();
        chk_dec("t2.rel", 21, 1'b1);
        chk("t2.fetch_resume", 32'(imem_en), 1);
        for (int k = 22; k <= 25; k++) begin
            step();
            chk_dec("t2.drain", k, 1'b1);
        end

        // T3: jump to 286 with hold=0
        jump   = 1'b1;
        new_pc = 10'd286;
        step();
        chk_dec("t3.jedge", 286, 1'b0);
        chk("t3.flush", 32'(q_level), 0);
        jump = 1'b0;
        step();
        chk_dec("t3.tgt", 286, 1'b1);
        step();
        chk_dec("t3.next", 287, 1'b1);

        // T4: jump while held with a full queue
        hold = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk_dec("t4.held", 287, 1'b1);
        chk("t4.q_full", 32'(q_level), 4);
        jump   = 1'b1;
        new_pc = 10'd61;
        step();
        chk_dec("t4.jedge", 61, 1'b0);
        chk("t4.flush", 32'(q_level), 0);
        jump = 1'b0;
        step();
        chk_dec("t4.tgt", 61, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_dec("t4.hold_tgt", 61, 1'b1);
        end
        hold = 1'b0;
        step();
        chk_dec("t4.rel", 62, 1'b1);
        step();
        chk_dec("t4.rel2", 63, 1'b1);

        // T5: PC wrap
        jump   = 1'b1;
        new_pc = 10'd1022;
        step();
        chk_dec("t5.jedge", 1022, 1'b0);
        jump = 1'b0;
        step();
        chk_dec("t5.1022", 1022, 1'b1);
        step();
        chk_dec("t5.1023", 1023, 1'b1);
        step();
        chk_dec("t5.wrap0", 0, 1'b1);
        step();
        chk_dec("t5.wrap1", 1, 1'b1);

        // T6: back-to-back jumps, last wins
        jump   = 1'b1;
        new_pc = 10'd100;
        step();
        chk_dec("t6.j100", 100, 1'b0);
        new_pc = 10'd200;
        step();
        chk_dec("t6.j200", 200, 1'b0);
        jump = 1'b0;
        step();
        chk_dec("t6.200", 200, 1'b1);
        step();
        chk_dec("t6.201", 201, 1'b1);

        // Reset mid-operation
        reset = 1'b0;
        step();
        chk_dec("rst2", 0, 1'b0);
        chk("rst2.q_level", 32'(q_level), 0);
        chk("rst2.imem_en", 32'(imem_en), 0);
        reset = 1'b1;
        step();
        chk("rst2.bubble", 32'(dec_valid), 0);
        step();
        chk_dec("rst2.pc0", 0, 1'b1);
        step();
        chk_dec("rst2.pc1", 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
